// File: rtl/tt_sel_pkg.sv
// tt_sel_pkg: shared FSM state type, default timing constants and a small helper for the select driver
package tt_sel_pkg;
  typedef enum logic [2:0] {IDLE, GUARD, RST, SETTLE, INC_HI, INC_LO, DONE} state_e;
  localparam int ADDR_W_DEF = 10;
  localparam int PULSE_CYC_DEF = 4;
  localparam int RST_CYC_DEF = 8;
  localparam int GUARD_CYC_DEF = 4;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/tt_sel_timer.sv
// tt_sel_timer: loadable down-counter with terminal-count flag
// ports: clk, rst_n (async low), load_i/val_i reload the count, tc_o high when the count is zero
module tt_sel_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (load_i) cnt_q <= val_i;
    else if (cnt_q != '0) cnt_q <= cnt_q - W'(1);
  assign tc_o = cnt_q == '0;
endmodule

// File: rtl/tt_sel_driver.sv
// tt_sel_driver: drives the sel_rst_n / sel_inc / ena design-select protocol towards the chip controller
// ports: req_valid/req_ready/req_addr/req_en request handshake; done/busy status;
//        cur_addr/cur_valid currently selected design; sel_rst_n/sel_inc/ena registered pad outputs
module tt_sel_driver
  import tt_sel_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int PULSE_CYC = PULSE_CYC_DEF,
  parameter int RST_CYC   = RST_CYC_DEF,
  parameter int GUARD_CYC = GUARD_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_en,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              cur_valid,
  output logic              sel_rst_n,
  output logic              sel_inc,
  output logic              ena
);
  localparam int TW = $clog2(max3(PULSE_CYC, RST_CYC, GUARD_CYC) + 1);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, cur_q, cur_d;
  logic rp_q, rp_d, en_q, en_d, valid_q, valid_d, ena_q, ena_d;
  logic srst_q, srst_d, inc_q, inc_d, done_q, done_d, busy_q, busy_d;
  logic accept, inc_path, enter, tc;
  logic [TW-1:0] tval;
  tt_sel_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load_i(enter),
    .val_i (tval),
    .tc_o  (tc)
  );
  assign accept   = req_valid && state_q == IDLE;
  // counting up from a known address avoids the selector reset
  assign inc_path = valid_q && req_addr >= cur_q;
  assign enter    = state_d != state_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:           state_d = req_valid ? GUARD : IDLE;
      GUARD:          if (tc) state_d = rp_q ? RST : (cnt_q != '0 ? INC_HI : DONE);
      RST:            if (tc) state_d = SETTLE;
      SETTLE, INC_LO: if (tc) state_d = cnt_q != '0 ? INC_HI : DONE;
      INC_HI:         if (tc) state_d = INC_LO;
      default:        state_d = IDLE;
    endcase
  end
  // every output and bookkeeping register is computed from the next state so it lines up with state_q
  always_comb begin
    rp_d    = accept ? !inc_path : rp_q;
    en_d    = accept ? req_en : en_q;
    cnt_d   = accept ? (inc_path ? req_addr - cur_q : req_addr)
            : (enter && state_d == INC_LO) ? cnt_q - ADDR_W'(1) : cnt_q;
    cur_d   = (enter && state_d == SETTLE) ? '0
            : (enter && state_d == INC_LO) ? cur_q + ADDR_W'(1) : cur_q;
    valid_d = valid_q || state_d == DONE;
    ena_d   = state_d == DONE ? en_q : state_d == IDLE ? ena_q : 1'b0;
    srst_d  = state_d != RST;
    inc_d   = state_d == INC_HI;
    done_d  = state_d == DONE;
    busy_d  = state_d != IDLE;
    tval    = state_d == GUARD ? TW'(GUARD_CYC - 1)
            : (state_d == RST || state_d == SETTLE) ? TW'(RST_CYC - 1) : TW'(PULSE_CYC - 1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      rp_q    <= 1'b0;
      en_q    <= 1'b0;
      valid_q <= 1'b0;
      ena_q   <= 1'b0;
      srst_q  <= 1'b1;
      inc_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      rp_q    <= rp_d;
      en_q    <= en_d;
      valid_q <= valid_d;
      ena_q   <= ena_d;
      srst_q  <= srst_d;
      inc_q   <= inc_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  assign req_ready = !busy_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cur_addr  = cur_q;
  assign cur_valid = valid_q;
  assign sel_rst_n = srst_q;
  assign sel_inc   = inc_q;
  assign ena       = ena_q;
endmodule

// File: tb/tb_tt_sel_driver.sv
// tb_tt_sel_driver: scoreboard bench for tt_sel_driver with short timing parameters
module tb_tt_sel_driver;
  localparam int AW = 10;
  localparam int P = 2;
  localparam int R = 4;
  localparam int G = 2;
  logic clk, rst_n, req_valid, req_ready, req_en, done, busy, cur_valid, sel_rst_n, sel_inc, ena;
  logic [AW-1:0] req_addr, cur_addr;
  typedef struct {
    int            lat;
    logic [AW-1:0] addr;
    logic          en;
    int            n;
    bit            rp;
  } exp_t;
  exp_t q[$];
  int n_checks = 0, n_fail = 0;
  int cyc = 0, acc_cyc = 0, n_done = 0, n_inc = 0, n_rst = 0, n_enalow = 0, viol = 0;
  logic [AW-1:0] m_cur = '0;
  bit m_valid = 0;
  logic prev_inc = 1'b0;
  tt_sel_driver #(.ADDR_W(AW), .PULSE_CYC(P), .RST_CYC(R), .GUARD_CYC(G)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_en   (req_en),
    .done     (done),
    .busy     (busy),
    .cur_addr (cur_addr),
    .cur_valid(cur_valid),
    .sel_rst_n(sel_rst_n),
    .sel_inc  (sel_inc),
    .ena      (ena)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      cyc++;
      if ((!sel_rst_n && sel_inc) || (ena && (!sel_rst_n || sel_inc)) || (req_ready == busy)) viol++;
      if (sel_inc && !prev_inc) n_inc++;
      if (!sel_rst_n) n_rst++;
      if (!ena) n_enalow++;
      if (done) begin
        n_done++;
        if (q.size() == 0) chk("sb_unexpected_done", 1, 0);
        else begin
          e = q.pop_front();
          chk("latency", cyc - acc_cyc, e.lat);
          chk("cur_addr", cur_addr, e.addr);
          chk("cur_valid", cur_valid, 1);
          chk("ena", ena, e.en);
          chk("inc_pulses", n_inc, e.n);
          chk("rst_low_cycles", n_rst, e.rp ? R : 0);
          chk("ena_low_cycles", n_enalow, e.lat - 1 + (e.en ? 0 : 1));
          chk("protocol_viol", viol, 0);
          m_cur = e.addr;
          m_valid = 1;
        end
      end
      if (req_valid && req_ready) begin
        e.rp   = !m_valid || req_addr < m_cur;
        e.n    = e.rp ? int'(req_addr) : int'(req_addr) - int'(m_cur);
        e.lat  = G + (e.rp ? 2 * R : 0) + e.n * 2 * P + 1;
        e.addr = req_addr;
        e.en   = req_en;
        q.push_back(e);
        acc_cyc = cyc;
        n_inc = 0;
        n_rst = 0;
        n_enalow = 0;
      end
      prev_inc = sel_inc;
    end
  end
  task automatic chk_idle(input string t);
    chk({t, "_sel_rst_n"}, sel_rst_n, 1);
    chk({t, "_sel_inc"}, sel_inc, 0);
    chk({t, "_ena"}, ena, 0);
    chk({t, "_done"}, done, 0);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_req_ready"}, req_ready, 1);
    chk({t, "_cur_addr"}, cur_addr, 0);
    chk({t, "_cur_valid"}, cur_valid, 0);
  endtask
  task automatic do_reset(input string t);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_idle(t);
    q.delete();
    m_valid = 0;
    m_cur = '0;
    prev_inc = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic send(input logic [AW-1:0] a, input logic e, input bit hold);
    int d0, t;
    d0 = n_done;
    @(posedge clk);
    #2 req_valid = 1'b1;
    req_addr = a;
    req_en = e;
    @(posedge clk);
    #2 req_valid = hold;
    req_addr = ~a;
    t = 0;
    while (n_done == d0 && t < 10000) begin
      @(negedge clk);
      #1 t++;
    end
    chk("done_seen", n_done != d0, 1);
    if (hold) begin
      @(posedge clk);
      #2 req_valid = 1'b0;
    end
  endtask
  initial begin
    int t;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_addr = '0;
    req_en = 1'b0;
    do_reset("rst0");
    send(10'd3, 1'b1, 1'b0);
    send(10'd5, 1'b1, 1'b0);
    send(10'd1, 1'b1, 1'b0);
    send(10'd1, 1'b0, 1'b0);
    do_reset("rst1");
    send(10'd0, 1'b1, 1'b0);
    send(10'd1023, 1'b1, 1'b0);
    @(posedge clk);
    #2 req_valid = 1'b1;
    req_addr = 10'd3;
    req_en = 1'b1;
    @(posedge clk);
    #2 req_valid = 1'b0;
    t = 0;
    while (!sel_inc && t < 200) begin
      @(negedge clk);
      #1 t++;
    end
    chk("midrst_inc_seen", sel_inc, 1);
    #2 rst_n = 1'b0;
    #1 chk_idle("midrst");
    q.delete();
    m_valid = 0;
    m_cur = '0;
    prev_inc = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    send(10'd2, 1'b1, 1'b0);
    send(10'd7, 1'b1, 1'b1);
    repeat (6) @(negedge clk);
    #1 chk("hold_no_reaccept_busy", busy, 0);
    chk("hold_cur_addr", cur_addr, 7);
    chk("sb_drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
